// File: rtl/soc_system_leds_pulse_out.sv
// Avalon-MM output PIO driving registered LED/actuator lines.
// Supports direct write, atomic set/clear, and timed one-shot pulses that release themselves.
module soc_system_leds_pulse_out #(
  parameter int WIDTH           = 8,
  parameter int CNT_W           = 16,
  parameter int PULSE_LEN_RESET = 1000,
  parameter int DATA_RESET      = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [WIDTH-1:0] DATA_INIT = WIDTH'(DATA_RESET);
  localparam logic [CNT_W-1:0] LEN_INIT  = CNT_W'(PULSE_LEN_RESET);

  logic [WIDTH-1:0] r_dataReg;
  logic [CNT_W-1:0] r_lenReg;
  logic [WIDTH-1:0] r_mask;
  logic [CNT_W-1:0] r_cnt;

  logic             w_wr;
  logic [WIDTH-1:0] w_wdData;
  logic [CNT_W-1:0] w_wdLen;
  logic             w_busy;
  logic             w_pulseWr;
  logic [31:0]      w_readMux;
  logic             w_unusedWd;

  assign w_wr      = chipselect & ~write_n;
  assign w_wdData  = writedata[WIDTH-1:0];
  assign w_wdLen   = writedata[CNT_W-1:0];
  assign w_busy    = (r_cnt != '0);
  // A pulse request with a zero programmed length is dropped entirely.
  assign w_pulseWr = w_wr && (address == 3'd3) && (r_lenReg != '0);
  // Upper writedata bits beyond WIDTH/CNT_W are intentionally ignored.
  assign w_unusedWd = &{1'b0, writedata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dataReg <= DATA_INIT;
      r_lenReg  <= LEN_INIT;
    end else if (w_wr) begin
      case (address)
        3'd0:    r_dataReg <= w_wdData;
        3'd2:    r_lenReg  <= w_wdLen;
        3'd4:    r_dataReg <= r_dataReg | w_wdData;
        3'd5:    r_dataReg <= r_dataReg & ~w_wdData;
        default: ;
      endcase
    end
  end

  // A new pulse write takes priority over expiry, so overlapping pulses merge and extend.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= '0;
      r_cnt  <= '0;
    end else if (w_pulseWr) begin
      r_mask <= r_mask | w_wdData;
      r_cnt  <= r_lenReg;
    end else if (w_busy) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) begin
        r_mask <= '0;
      end
    end
  end

  always_comb begin
    w_readMux = '0;
    case (address)
      3'd0:    w_readMux[WIDTH-1:0] = r_dataReg;
      3'd1:    w_readMux[0]         = w_busy;
      3'd2:    w_readMux[CNT_W-1:0] = r_lenReg;
      3'd3:    w_readMux[WIDTH-1:0] = r_mask;
      default: w_readMux            = '0;
    endcase
  end

  // Reads ignore chipselect and return the pre-write register state one clock later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      out_port <= DATA_INIT;
    end else begin
      readdata <= w_readMux;
      out_port <= r_dataReg | r_mask;
    end
  end

endmodule

// File: tb/tb_soc_system_leds_pulse_out.sv
// Self-checking bench for soc_system_leds_pulse_out: a vector table for register
// behaviour plus hand-written pulse, overlap and mid-pulse reset sequences.
module tb_soc_system_leds_pulse_out;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int nApplied;
  int nMiscompares;

  typedef struct {
    logic [2:0]  addr;
    logic        cs;
    logic        wn;
    logic [31:0] wd;
    logic [7:0]  expOut;
    logic [31:0] expRd;
  } vec_t;

  vec_t vecs[25];

  soc_system_leds_pulse_out #(
    .WIDTH(8),
    .CNT_W(16),
    .PULSE_LEN_RESET(1000),
    .DATA_RESET(0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one bus cycle, then settle just after the rising edge for sampling.
  task automatic applyStimulus(input logic [2:0] addr, input logic cs, input logic wn,
                               input logic [31:0] wd);
    address    = addr;
    chipselect = cs;
    write_n    = wn;
    writedata  = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nApplied++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic writeReg(input logic [2:0] addr, input logic [31:0] wd);
    applyStimulus(addr, 1'b1, 1'b0, wd);
  endtask

  task automatic readReg(input logic [2:0] addr);
    applyStimulus(addr, 1'b0, 1'b1, 32'h0);
  endtask

  initial begin
    nApplied     = 0;
    nMiscompares = 0;
    reset_n      = 1'b0;
    address      = 3'd0;
    chipselect   = 1'b0;
    write_n      = 1'b1;
    writedata    = 32'h0;

    // addr, cs, wn, wd, expected out_port, expected readdata (sampled after the edge)
    vecs[0]  = '{3'd2, 1'b0, 1'b1, 32'h0,       8'h00, 32'd1000};
    vecs[1]  = '{3'd1, 1'b0, 1'b1, 32'h0,       8'h00, 32'h0};
    vecs[2]  = '{3'd0, 1'b1, 1'b0, 32'hA5,      8'h00, 32'h0};
    vecs[3]  = '{3'd4, 1'b1, 1'b0, 32'h0A,      8'hA5, 32'h0};
    vecs[4]  = '{3'd5, 1'b1, 1'b0, 32'h81,      8'hAF, 32'h0};
    vecs[5]  = '{3'd0, 1'b0, 1'b1, 32'h0,       8'h2E, 32'h2E};
    vecs[6]  = '{3'd0, 1'b1, 1'b0, 32'h55,      8'h2E, 32'h2E};
    vecs[7]  = '{3'd0, 1'b0, 1'b1, 32'h0,       8'h55, 32'h55};
    vecs[8]  = '{3'd6, 1'b1, 1'b0, 32'hFF,      8'h55, 32'h0};
    vecs[9]  = '{3'd6, 1'b0, 1'b1, 32'h0,       8'h55, 32'h0};
    vecs[10] = '{3'd1, 1'b1, 1'b0, 32'hFF,      8'h55, 32'h0};
    vecs[11] = '{3'd1, 1'b0, 1'b1, 32'h0,       8'h55, 32'h0};
    vecs[12] = '{3'd0, 1'b0, 1'b1, 32'h0,       8'h55, 32'h55};
    vecs[13] = '{3'd2, 1'b1, 1'b0, 32'h0,       8'h55, 32'd1000};
    vecs[14] = '{3'd3, 1'b1, 1'b0, 32'hFF,      8'h55, 32'h0};
    vecs[15] = '{3'd1, 1'b0, 1'b1, 32'h0,       8'h55, 32'h0};
    vecs[16] = '{3'd3, 1'b0, 1'b1, 32'h0,       8'h55, 32'h0};
    vecs[17] = '{3'd2, 1'b0, 1'b1, 32'h0,       8'h55, 32'h0};
    vecs[18] = '{3'd0, 1'b1, 1'b0, 32'h0,       8'h55, 32'h55};
    vecs[19] = '{3'd2, 1'b1, 1'b0, 32'h12345,   8'h00, 32'h0};
    vecs[20] = '{3'd2, 1'b0, 1'b1, 32'h0,       8'h00, 32'h2345};
    vecs[21] = '{3'd0, 1'b1, 1'b0, 32'h1FF,     8'h00, 32'h0};
    vecs[22] = '{3'd0, 1'b0, 1'b1, 32'h0,       8'hFF, 32'hFF};
    vecs[23] = '{3'd5, 1'b1, 1'b0, 32'hFF,      8'hFF, 32'h0};
    vecs[24] = '{3'd0, 1'b0, 1'b1, 32'h0,       8'h00, 32'h0};

    #2;
    checkOutput("reset out_port", {24'h0, out_port}, 32'h0);
    checkOutput("reset readdata", readdata, 32'h0);
    #10;
    reset_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].cs, vecs[i].wn, vecs[i].wd);
      checkOutput($sformatf("vec%0d out_port", i), {24'h0, out_port}, {24'h0, vecs[i].expOut});
      checkOutput($sformatf("vec%0d readdata", i), readdata, vecs[i].expRd);
    end

    // Single 5-clock pulse; PULSE_LEN rewritten mid-pulse must not disturb it.
    writeReg(3'd2, 32'd5);
    writeReg(3'd3, 32'h03);
    checkOutput("pulse edge out_port", {24'h0, out_port}, 32'h0);
    for (int k = 1; k <= 7; k++) begin
      if (k == 2) begin
        writeReg(3'd2, 32'd9);
        checkOutput("len write busy readdata", readdata, 32'd5);
      end else begin
        readReg(3'd1);
        checkOutput($sformatf("pulse k%0d status", k), readdata, (k <= 5) ? 32'h1 : 32'h0);
      end
      checkOutput($sformatf("pulse k%0d out_port", k), {24'h0, out_port},
                  (k <= 5) ? 32'h03 : 32'h0);
    end
    readReg(3'd2);
    checkOutput("len after busy write", readdata, 32'd9);

    // Second pulse lands on the expiry edge of the first and extends the old bit.
    writeReg(3'd2, 32'd4);
    writeReg(3'd3, 32'h01);
    checkOutput("overlap edge readdata", readdata, 32'h0);
    for (int k = 1; k <= 10; k++) begin
      if (k == 4) writeReg(3'd3, 32'h02);
      else        readReg(3'd3);
      checkOutput($sformatf("overlap k%0d out_port", k), {24'h0, out_port},
                  (k <= 4) ? 32'h01 : (k <= 8) ? 32'h03 : 32'h0);
      checkOutput($sformatf("overlap k%0d mask", k), readdata,
                  (k <= 4) ? 32'h01 : (k <= 8) ? 32'h03 : 32'h0);
    end

    // Data bit cleared while the mask holds it high stays high on out_port.
    writeReg(3'd0, 32'h3C);
    writeReg(3'd2, 32'd20);
    writeReg(3'd3, 32'h04);
    writeReg(3'd5, 32'h04);
    readReg(3'd1);
    checkOutput("mask holds cleared bit", {24'h0, out_port}, 32'h3C);
    checkOutput("busy mid pulse", readdata, 32'h1);

    // Asynchronous reset in the middle of the pulse.
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("async reset out_port", {24'h0, out_port}, 32'h0);
    checkOutput("async reset readdata", readdata, 32'h0);
    #2;
    reset_n = 1'b1;
    readReg(3'd1);
    checkOutput("post reset status", readdata, 32'h0);
    readReg(3'd2);
    checkOutput("post reset pulse_len", readdata, 32'd1000);
    readReg(3'd3);
    checkOutput("post reset mask", readdata, 32'h0);
    readReg(3'd0);
    checkOutput("post reset data", readdata, 32'h0);
    checkOutput("post reset out_port", {24'h0, out_port}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompares);
    $finish;
  end

endmodule
